dq_array_mem: RTL and testbench

//  Parametrised word-addressed storage array built as the next generation of
//  the DQ flip-flop array: DEPTH words of WIDTH bits, one write port, one

---
 rtl/dq_array_mem.sv | 114 +++++++++++
 tb/tb_dq_array_mem.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dq_array_mem.sv
// Word-addressed flip-flop array with one write port, one registered
// read port and a multi-cycle sweep-clear engine.
module dq_array_mem #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic idle_go;
  logic wr_ok;
  logic rd_go;
  logic rd_ok;
  logic hit;

  // clr takes priority over any access in the same cycle
  assign idle_go = (state == IDLE) && !clr;
  assign wr_ok   = idle_go && we && ({1'b0, waddr} < DEPTH_W);
  assign rd_go   = idle_go && re;
  assign rd_ok   = {1'b0, raddr} < DEPTH_W;
  assign hit     = wr_ok && (waddr == raddr);
  assign busy    = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // write-first on a same-address collision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_go;
      if (rd_go) begin
        if (!rd_ok) begin
          rdata <= '0;
        end else if (hit) begin
          rdata <= wdata;
        end else begin
          rdata <= mem[raddr];
        end
      end
    end
  end

endmodule

// File: tb/tb_dq_array_mem.sv
// Scoreboard bench for dq_array_mem: an 8-word and a 6-word instance.
module tb_dq_array_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       clr8 = 1'b0;
  logic       we8 = 1'b0;
  logic [2:0] wa8 = '0;
  logic [3:0] wd8 = '0;
  logic       re8 = 1'b0;
  logic [2:0] ra8 = '0;
  logic [3:0] rdata8;
  logic       rvalid8;
  logic       busy8;

  logic       clr6 = 1'b0;
  logic       we6 = 1'b0;
  logic [2:0] wa6 = '0;
  logic [3:0] wd6 = '0;
  logic       re6 = 1'b0;
  logic [2:0] ra6 = '0;
  logic [3:0] rdata6;
  logic       rvalid6;
  logic       busy6;

  int checks = 0;
  int errors = 0;

  logic [3:0] q8[$];
  logic [3:0] q6[$];

  always #5 clk = ~clk;

  dq_array_mem #(.WIDTH(4), .DEPTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8),
    .we(we8), .waddr(wa8), .wdata(wd8),
    .re(re8), .raddr(ra8),
    .rdata(rdata8), .rvalid(rvalid8), .busy(busy8)
  );

  dq_array_mem #(.WIDTH(4), .DEPTH(6)) d6 (
    .clk(clk), .rst_n(rst_n), .clr(clr6),
    .we(we6), .waddr(wa6), .wdata(wd6),
    .re(re6), .raddr(ra6),
    .rdata(rdata6), .rvalid(rvalid6), .busy(busy6)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // monitor: pop and compare whenever a read result appears
  always @(negedge clk) begin
    if (rvalid8 === 1'b1) begin
      if (q8.size() == 0) chk("unexpected_rvalid8", 1, 0);
      else chk("rdata8", {28'd0, rdata8}, {28'd0, q8.pop_front()});
    end
    if (rvalid6 === 1'b1) begin
      if (q6.size() == 0) chk("unexpected_rvalid6", 1, 0);
      else chk("rdata6", {28'd0, rdata6}, {28'd0, q6.pop_front()});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
    we8 = 1'b0; re8 = 1'b0; clr8 = 1'b0;
    we6 = 1'b0; re6 = 1'b0; clr6 = 1'b0;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [3:0] d);
    we8 = 1'b1; wa8 = a; wd8 = d;
    step();
  endtask

  task automatic rd8(input logic [2:0] a, input logic [3:0] e);
    re8 = 1'b1; ra8 = a;
    q8.push_back(e);
    step();
  endtask

  task automatic wr6(input logic [2:0] a, input logic [3:0] d);
    we6 = 1'b1; wa6 = a; wd6 = d;
    step();
  endtask

  task automatic rd6(input logic [2:0] a, input logic [3:0] e);
    re6 = 1'b1; ra6 = a;
    q6.push_back(e);
    step();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    do_reset();
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_rvalid", {31'd0, rvalid8}, 0);
    chk("rst_rdata", {28'd0, rdata8}, 0);

    // 1: writes then reset, everything reads back zero
    wr8(0, 4'h3); wr8(1, 4'h9); wr8(4, 4'hE); wr8(7, 4'h5);
    do_reset();
    chk("t1_busy", {31'd0, busy8}, 0);
    chk("t1_rvalid", {31'd0, rvalid8}, 0);
    for (int i = 0; i < 8; i++) rd8(3'(i), 4'h0);
    step();

    // 2: write then read, single-cycle rvalid
    wr8(3, 4'hA);
    rd8(3, 4'hA);
    chk("t2_rvalid_hi", {31'd0, rvalid8}, 1);
    step();
    chk("t2_rvalid_lo", {31'd0, rvalid8}, 0);
    chk("t2_rdata_hold", {28'd0, rdata8}, 4'hA);

    // 3: write-first on collision, independent otherwise
    wr8(5, 4'h1);
    we8 = 1'b1; wa8 = 5; wd8 = 4'h6;
    re8 = 1'b1; ra8 = 5; q8.push_back(4'h6);
    step();
    rd8(5, 4'h6);
    we8 = 1'b1; wa8 = 2; wd8 = 4'h9;
    re8 = 1'b1; ra8 = 3; q8.push_back(4'hA);
    step();
    rd8(2, 4'h9);
    step();

    // 4: fill, sweep, accesses during busy dropped
    for (int i = 0; i < 8; i++) wr8(3'(i), 4'(8 - i));
    rd8(0, 4'h8);
    rd8(6, 4'h2);
    clr8 = 1'b1; we8 = 1'b1; wa8 = 0; wd8 = 4'hF;
    re8 = 1'b1; ra8 = 1;
    step();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy8 !== 1'b1) break;
      chk("t4_rvalid_busy", {31'd0, rvalid8}, 0);
      n++;
      we8 = 1'b1; wa8 = 3'(k); wd8 = 4'h7;
      re8 = 1'b1; ra8 = 3'(k);
      clr8 = 1'b1;
      step();
    end
    chk("t4_busy_cycles", n, 8);
    chk("t4_rvalid_after", {31'd0, rvalid8}, 0);
    for (int i = 0; i < 8; i++) rd8(3'(i), 4'h0);
    step();

    // 6: reset in the middle of a sweep
    wr8(1, 4'hB); wr8(6, 4'hD);
    clr8 = 1'b1;
    step();
    step(); step(); step();
    chk("t6_busy_mid", {31'd0, busy8}, 1);
    do_reset();
    chk("t6_busy", {31'd0, busy8}, 0);
    chk("t6_rvalid", {31'd0, rvalid8}, 0);
    for (int i = 0; i < 8; i++) rd8(3'(i), 4'h0);
    wr8(2, 4'hC);
    rd8(2, 4'hC);
    step();

    // 5: out-of-range addresses on the 6-word instance
    for (int i = 0; i < 6; i++) wr6(3'(i), 4'(i + 1));
    wr6(7, 4'hF);
    wr6(6, 4'hE);
    rd6(6, 4'h0);
    rd6(7, 4'h0);
    chk("t5_rvalid", {31'd0, rvalid6}, 1);
    for (int i = 0; i < 6; i++) rd6(3'(i), 4'(i + 1));
    step(); step();

    chk("q8_drained", q8.size(), 0);
    chk("q6_drained", q6.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
